// File: rtl/can_tx_priority_logic_if.sv
// Bus between the TX message storage (HPB + TX FIFO), the bit stream processor
// and the TX priority logic. The DUT side uses the slave modport.
interface can_tx_priority_logic_if;
   logic         i_hpb_full;
   logic [127:0] i_hpb_r_data;
   logic         o_hpb_r_en;
   logic         i_tx_empty;
   logic [127:0] i_tx_fifo_r_data;
   logic         o_tx_fifo_r_en;
   logic [127:0] o_tx_message;
   logic         o_tx_req;
   logic         i_tx_done;
   logic         i_tx_arb_lost;
   logic         i_tx_error;
   logic         o_txok;
   logic         o_txdrop;
   logic         o_txbsy;
   logic [7:0]   o_retry_cnt;
   logic [1:0]   dbg_state;
   logic         dbg_src;

   modport master (
      output i_hpb_full, i_hpb_r_data, i_tx_empty, i_tx_fifo_r_data,
             i_tx_done, i_tx_arb_lost, i_tx_error,
      input  o_hpb_r_en, o_tx_fifo_r_en, o_tx_message, o_tx_req,
             o_txok, o_txdrop, o_txbsy, o_retry_cnt, dbg_state, dbg_src
   );

   modport slave (
      input  i_hpb_full, i_hpb_r_data, i_tx_empty, i_tx_fifo_r_data,
             i_tx_done, i_tx_arb_lost, i_tx_error,
      output o_hpb_r_en, o_tx_fifo_r_en, o_tx_message, o_tx_req,
             o_txok, o_txdrop, o_txbsy, o_retry_cnt, dbg_state, dbg_src
   );
endinterface

// File: rtl/can_tx_priority_logic.sv
// Picks the next CAN frame (HPB before TX FIFO), holds it for the BSP and
// tracks success / arbitration loss / error with a bounded retry count.
module can_tx_priority_logic #(
   parameter int unsigned MAX_RETRY = 0
) (
   input  logic                    i_sys_clk,
   input  logic                    i_reset_n,
   can_tx_priority_logic_if.slave  bus
);
   // Handshakes: a source is offered while i_hpb_full=1 / i_tx_empty=0 and is
   // taken by a 1-cycle r_en pulse; o_tx_req is a level held with a stable
   // o_tx_message until the BSP answers with exactly one done/error/arb_lost pulse.
   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, REQ = 2'd2, GAP = 2'd3} state_t;

   localparam logic [7:0] RETRY_LIMIT   = 8'(MAX_RETRY);
   localparam bit         RETRY_FOREVER = (MAX_RETRY == 0);

   state_t       state;
   logic         src_hpb;
   logic [127:0] message;
   logic         req;
   logic         hpb_r_en;
   logic         fifo_r_en;
   logic         txok;
   logic         txdrop;
   logic         busy;
   logic [7:0]   retry_cnt;
   logic         attempt_failed;

   assign attempt_failed = bus.i_tx_error | bus.i_tx_arb_lost;

   always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= IDLE;
         src_hpb   <= 1'b0;
         message   <= '0;
         req       <= 1'b0;
         hpb_r_en  <= 1'b0;
         fifo_r_en <= 1'b0;
         txok      <= 1'b0;
         txdrop    <= 1'b0;
         busy      <= 1'b0;
         retry_cnt <= '0;
      end else begin
         hpb_r_en  <= 1'b0;
         fifo_r_en <= 1'b0;
         txok      <= 1'b0;
         txdrop    <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_hpb_full) begin
                  hpb_r_en  <= 1'b1;
                  message   <= bus.i_hpb_r_data;
                  src_hpb   <= 1'b1;
                  retry_cnt <= '0;
                  req       <= 1'b1;
                  busy      <= 1'b1;
                  state     <= REQ;
               end else if (!bus.i_tx_empty) begin
                  fifo_r_en <= 1'b1;
                  busy      <= 1'b1;
                  state     <= FETCH;
               end
            end
            FETCH: begin
               message   <= bus.i_tx_fifo_r_data;
               src_hpb   <= 1'b0;
               retry_cnt <= '0;
               req       <= 1'b1;
               state     <= REQ;
            end
            REQ: begin
               // done outranks error/arb_lost when pulses coincide
               if (bus.i_tx_done) begin
                  txok  <= 1'b1;
                  req   <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (attempt_failed) begin
                  req <= 1'b0;
                  if (!RETRY_FOREVER && retry_cnt == RETRY_LIMIT) begin
                     txdrop <= 1'b1;
                     busy   <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
                     state <= GAP;
                  end
               end
            end
            GAP: begin
               req   <= 1'b1;
               state <= REQ;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_hpb_r_en     = hpb_r_en;
   assign bus.o_tx_fifo_r_en = fifo_r_en;
   assign bus.o_tx_message   = message;
   assign bus.o_tx_req       = req;
   assign bus.o_txok         = txok;
   assign bus.o_txdrop       = txdrop;
   assign bus.o_txbsy        = busy;
   assign bus.o_retry_cnt    = retry_cnt;
   assign bus.dbg_state      = state;
   assign bus.dbg_src        = src_hpb;
endmodule

// File: tb/tb_can_tx_priority_logic.sv
// Bench for can_tx_priority_logic: one instance with MAX_RETRY=2, one with
// MAX_RETRY=0; messages are queued on drive and popped when the BSP request appears.
module tb_can_tx_priority_logic;
   localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_REQ = 2'd2, S_GAP = 2'd3;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [127:0] exp_q[$];

   always #5 clk = ~clk;

   can_tx_priority_logic_if bus_a ();
   can_tx_priority_logic_if bus_b ();

   can_tx_priority_logic #(.MAX_RETRY(2)) u_dut_r2 (.i_sys_clk(clk), .i_reset_n(rst_n), .bus(bus_a));
   can_tx_priority_logic #(.MAX_RETRY(0)) u_dut_r0 (.i_sys_clk(clk), .i_reset_n(rst_n), .bus(bus_b));

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic init_inputs();
      bus_a.i_hpb_full = 1'b0;  bus_a.i_hpb_r_data = '0;
      bus_a.i_tx_empty = 1'b1;  bus_a.i_tx_fifo_r_data = '0;
      bus_a.i_tx_done = 1'b0;   bus_a.i_tx_arb_lost = 1'b0; bus_a.i_tx_error = 1'b0;
      bus_b.i_hpb_full = 1'b0;  bus_b.i_hpb_r_data = '0;
      bus_b.i_tx_empty = 1'b1;  bus_b.i_tx_fifo_r_data = '0;
      bus_b.i_tx_done = 1'b0;   bus_b.i_tx_arb_lost = 1'b0; bus_b.i_tx_error = 1'b0;
   endtask

   task automatic drive_hpb_a(input logic [127:0] msg);
      bus_a.i_hpb_full = 1'b1;
      bus_a.i_hpb_r_data = msg;
      exp_q.push_back(msg);
      tick();
      bus_a.i_hpb_full = 1'b0;
   endtask

   task automatic drive_hpb_b(input logic [127:0] msg);
      bus_b.i_hpb_full = 1'b1;
      bus_b.i_hpb_r_data = msg;
      exp_q.push_back(msg);
      tick();
      bus_b.i_hpb_full = 1'b0;
   endtask

   task automatic pulse_done_a();
      bus_a.i_tx_done = 1'b1;
      tick();
      bus_a.i_tx_done = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      init_inputs();
      repeat (2) tick();
      n_cmp++; if (bus_a.o_tx_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", bus_a.o_tx_req); end
      n_cmp++; if (bus_a.o_tx_message !== 128'h0) begin n_err++; $display("FAIL reset_msg: got %h want 0", bus_a.o_tx_message); end
      n_cmp++; if ({bus_a.o_hpb_r_en, bus_a.o_tx_fifo_r_en, bus_a.o_txok, bus_a.o_txdrop, bus_a.o_txbsy} !== 5'b0) begin
         n_err++; $display("FAIL reset_pulses: got %b want 00000",
            {bus_a.o_hpb_r_en, bus_a.o_tx_fifo_r_en, bus_a.o_txok, bus_a.o_txdrop, bus_a.o_txbsy}); end
      n_cmp++; if (bus_a.o_retry_cnt !== 8'd0) begin n_err++; $display("FAIL reset_retry: got %0d want 0", bus_a.o_retry_cnt); end
      n_cmp++; if (bus_a.dbg_state !== S_IDLE || bus_a.dbg_src !== 1'b0) begin
         n_err++; $display("FAIL reset_state: got state %0d src %b want 0 0", bus_a.dbg_state, bus_a.dbg_src); end
      n_cmp++; if (bus_b.o_tx_req !== 1'b0 || bus_b.o_txbsy !== 1'b0) begin
         n_err++; $display("FAIL reset_b: got req %b bsy %b want 0 0", bus_b.o_tx_req, bus_b.o_txbsy); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fifo_basic();
      logic [127:0] msg;
      msg = {16{8'hA5}};
      bus_a.i_tx_fifo_r_data = msg;
      bus_a.i_tx_empty = 1'b0;
      exp_q.push_back(msg);
      tick();
      bus_a.i_tx_empty = 1'b1;
      n_cmp++; if (bus_a.o_tx_fifo_r_en !== 1'b1 || bus_a.o_hpb_r_en !== 1'b0 || bus_a.o_tx_req !== 1'b0) begin
         n_err++; $display("FAIL fifo_fetch: got fifo_r_en %b hpb_r_en %b req %b want 1 0 0",
            bus_a.o_tx_fifo_r_en, bus_a.o_hpb_r_en, bus_a.o_tx_req); end
      n_cmp++; if (bus_a.o_txbsy !== 1'b1) begin n_err++; $display("FAIL fifo_bsy_fetch: got %b want 1", bus_a.o_txbsy); end
      tick();
      n_cmp++; if (bus_a.o_tx_req !== 1'b1 || bus_a.o_tx_fifo_r_en !== 1'b0) begin
         n_err++; $display("FAIL fifo_req: got req %b r_en %b want 1 0", bus_a.o_tx_req, bus_a.o_tx_fifo_r_en); end
      n_cmp++; if (bus_a.o_tx_message !== exp_q[0]) begin
         n_err++; $display("FAIL fifo_msg: got %h want %h", bus_a.o_tx_message, exp_q[0]); end
      void'(exp_q.pop_front());
      bus_a.i_tx_fifo_r_data = '1;
      repeat (3) tick();
      n_cmp++; if (bus_a.o_tx_message !== msg || bus_a.o_tx_req !== 1'b1) begin
         n_err++; $display("FAIL fifo_hold: got %h req %b want %h 1", bus_a.o_tx_message, bus_a.o_tx_req, msg); end
      pulse_done_a();
      n_cmp++; if (bus_a.o_txok !== 1'b1 || bus_a.o_tx_req !== 1'b0 || bus_a.dbg_state !== S_IDLE) begin
         n_err++; $display("FAIL fifo_txok: got ok %b req %b state %0d want 1 0 0",
            bus_a.o_txok, bus_a.o_tx_req, bus_a.dbg_state); end
      tick();
      n_cmp++; if (bus_a.o_txok !== 1'b0 || bus_a.o_txbsy !== 1'b0) begin
         n_err++; $display("FAIL fifo_ok_pulse: got ok %b bsy %b want 0 0", bus_a.o_txok, bus_a.o_txbsy); end
   endtask

   task automatic test_hpb_priority();
      logic [127:0] h_msg, f_msg;
      h_msg = {$urandom, $urandom, $urandom, $urandom};
      f_msg = {$urandom, $urandom, $urandom, $urandom};
      bus_a.i_tx_fifo_r_data = f_msg;
      bus_a.i_tx_empty = 1'b0;
      drive_hpb_a(h_msg);
      exp_q.push_back(f_msg);
      n_cmp++; if (bus_a.o_hpb_r_en !== 1'b1 || bus_a.o_tx_fifo_r_en !== 1'b0) begin
         n_err++; $display("FAIL prio_r_en: got hpb %b fifo %b want 1 0", bus_a.o_hpb_r_en, bus_a.o_tx_fifo_r_en); end
      n_cmp++; if (bus_a.o_tx_req !== 1'b1 || bus_a.o_tx_message !== exp_q[0] || bus_a.dbg_src !== 1'b1) begin
         n_err++; $display("FAIL prio_hpb_msg: got req %b msg %h src %b want 1 %h 1",
            bus_a.o_tx_req, bus_a.o_tx_message, bus_a.dbg_src, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
      tick();
      n_cmp++; if (bus_a.o_hpb_r_en !== 1'b0 || bus_a.o_tx_fifo_r_en !== 1'b0) begin
         n_err++; $display("FAIL prio_no_preempt: got hpb %b fifo %b want 0 0", bus_a.o_hpb_r_en, bus_a.o_tx_fifo_r_en); end
      pulse_done_a();
      n_cmp++; if (bus_a.o_txok !== 1'b1) begin n_err++; $display("FAIL prio_ok1: got %b want 1", bus_a.o_txok); end
      tick();
      bus_a.i_tx_empty = 1'b1;
      n_cmp++; if (bus_a.o_tx_fifo_r_en !== 1'b1) begin n_err++; $display("FAIL prio_fifo_next: got %b want 1", bus_a.o_tx_fifo_r_en); end
      tick();
      n_cmp++; if (bus_a.o_tx_req !== 1'b1 || bus_a.o_tx_message !== exp_q[0] || bus_a.dbg_src !== 1'b0) begin
         n_err++; $display("FAIL prio_fifo_msg: got req %b msg %h src %b want 1 %h 0",
            bus_a.o_tx_req, bus_a.o_tx_message, bus_a.dbg_src, exp_q[0]); end
      void'(exp_q.pop_front());
      pulse_done_a();
      n_cmp++; if (bus_a.o_txok !== 1'b1) begin n_err++; $display("FAIL prio_ok2: got %b want 1", bus_a.o_txok); end
      tick();
   endtask

   task automatic test_retry_drop();
      logic [127:0] msg;
      msg = {4{32'hC0DE_0000 | 32'($urandom_range(0, 16'hFFFF))}};
      drive_hpb_a(msg);
      n_cmp++; if (bus_a.o_tx_message !== exp_q[0] || bus_a.o_retry_cnt !== 8'd0) begin
         n_err++; $display("FAIL drop_load: got %h retry %0d want %h 0", bus_a.o_tx_message, bus_a.o_retry_cnt, exp_q[0]); end
      void'(exp_q.pop_front());
      for (int i = 1; i <= 2; i++) begin
         bus_a.i_tx_arb_lost = 1'b1;
         tick();
         bus_a.i_tx_arb_lost = 1'b0;
         n_cmp++; if (bus_a.o_tx_req !== 1'b0 || bus_a.o_retry_cnt !== 8'(i) || bus_a.dbg_state !== S_GAP || bus_a.o_txdrop !== 1'b0) begin
            n_err++; $display("FAIL drop_gap%0d: got req %b retry %0d state %0d drop %b want 0 %0d 3 0",
               i, bus_a.o_tx_req, bus_a.o_retry_cnt, bus_a.dbg_state, bus_a.o_txdrop, i); end
         tick();
         n_cmp++; if (bus_a.o_tx_req !== 1'b1 || bus_a.o_tx_message !== msg) begin
            n_err++; $display("FAIL drop_rereq%0d: got req %b msg %h want 1 %h", i, bus_a.o_tx_req, bus_a.o_tx_message, msg); end
      end
      bus_a.i_tx_arb_lost = 1'b1;
      tick();
      bus_a.i_tx_arb_lost = 1'b0;
      n_cmp++; if (bus_a.o_txdrop !== 1'b1 || bus_a.o_txok !== 1'b0 || bus_a.o_tx_req !== 1'b0 || bus_a.dbg_state !== S_IDLE) begin
         n_err++; $display("FAIL drop_final: got drop %b ok %b req %b state %0d want 1 0 0 0",
            bus_a.o_txdrop, bus_a.o_txok, bus_a.o_tx_req, bus_a.dbg_state); end
      tick();
      n_cmp++; if (bus_a.o_txdrop !== 1'b0 || bus_a.o_txbsy !== 1'b0) begin
         n_err++; $display("FAIL drop_pulse: got drop %b bsy %b want 0 0", bus_a.o_txdrop, bus_a.o_txbsy); end
   endtask

   task automatic test_retry_forever();
      logic [127:0] msg;
      int bad;
      logic [7:0] want;
      bad = 0;
      msg = {32'h1234_5678, 96'($urandom)};
      drive_hpb_b(msg);
      n_cmp++; if (bus_b.o_tx_req !== 1'b1 || bus_b.o_tx_message !== exp_q[0]) begin
         n_err++; $display("FAIL inf_load: got req %b msg %h want 1 %h", bus_b.o_tx_req, bus_b.o_tx_message, exp_q[0]); end
      void'(exp_q.pop_front());
      for (int i = 1; i <= 300; i++) begin
         bus_b.i_tx_error = 1'b1;
         tick();
         bus_b.i_tx_error = 1'b0;
         want = (i < 255) ? 8'(i) : 8'd255;
         if (bus_b.o_retry_cnt !== want || bus_b.o_txdrop !== 1'b0 || bus_b.o_tx_req !== 1'b0 || bus_b.o_txbsy !== 1'b1) bad++;
         tick();
         if (bus_b.o_tx_req !== 1'b1 || bus_b.o_tx_message !== msg) bad++;
      end
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL inf_loop: got %0d bad cycles want 0", bad); end
      n_cmp++; if (bus_b.o_retry_cnt !== 8'd255) begin n_err++; $display("FAIL inf_sat: got %0d want 255", bus_b.o_retry_cnt); end
      bus_b.i_tx_done = 1'b1;
      tick();
      bus_b.i_tx_done = 1'b0;
      n_cmp++; if (bus_b.o_txok !== 1'b1 || bus_b.o_txdrop !== 1'b0 || bus_b.dbg_state !== S_IDLE) begin
         n_err++; $display("FAIL inf_done: got ok %b drop %b state %0d want 1 0 0", bus_b.o_txok, bus_b.o_txdrop, bus_b.dbg_state); end
      tick();
   endtask

   task automatic test_coincident();
      drive_hpb_a(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
      n_cmp++; if (bus_a.o_tx_message !== exp_q[0]) begin
         n_err++; $display("FAIL coin_msg: got %h want %h", bus_a.o_tx_message, exp_q[0]); end
      void'(exp_q.pop_front());
      bus_a.i_tx_done = 1'b1; bus_a.i_tx_error = 1'b1; bus_a.i_tx_arb_lost = 1'b1;
      tick();
      bus_a.i_tx_done = 1'b0; bus_a.i_tx_error = 1'b0; bus_a.i_tx_arb_lost = 1'b0;
      n_cmp++; if (bus_a.o_txok !== 1'b1 || bus_a.o_txdrop !== 1'b0 || bus_a.o_retry_cnt !== 8'd0 || bus_a.dbg_state !== S_IDLE) begin
         n_err++; $display("FAIL coin_outcome: got ok %b drop %b retry %0d state %0d want 1 0 0 0",
            bus_a.o_txok, bus_a.o_txdrop, bus_a.o_retry_cnt, bus_a.dbg_state); end
      tick();
   endtask

   task automatic test_stray_pulse();
      bus_a.i_tx_done = 1'b1; bus_a.i_tx_arb_lost = 1'b1;
      tick();
      bus_a.i_tx_done = 1'b0; bus_a.i_tx_arb_lost = 1'b0;
      n_cmp++; if (bus_a.o_txok !== 1'b0 || bus_a.o_txdrop !== 1'b0 || bus_a.o_tx_req !== 1'b0 || bus_a.dbg_state !== S_IDLE) begin
         n_err++; $display("FAIL stray: got ok %b drop %b req %b state %0d want 0 0 0 0",
            bus_a.o_txok, bus_a.o_txdrop, bus_a.o_tx_req, bus_a.dbg_state); end
   endtask

   task automatic test_reset_mid();
      logic [127:0] x_msg, y_msg;
      x_msg = {$urandom, $urandom, $urandom, $urandom};
      y_msg = ~x_msg;
      bus_a.i_tx_fifo_r_data = x_msg;
      bus_a.i_tx_empty = 1'b0;
      exp_q.push_back(x_msg);
      tick();
      bus_a.i_tx_empty = 1'b1;
      tick();
      n_cmp++; if (bus_a.o_tx_req !== 1'b1 || bus_a.o_tx_message !== exp_q[0]) begin
         n_err++; $display("FAIL rmid_req: got req %b msg %h want 1 %h", bus_a.o_tx_req, bus_a.o_tx_message, exp_q[0]); end
      void'(exp_q.pop_front());
      bus_a.i_tx_fifo_r_data = y_msg;
      bus_a.i_tx_empty = 1'b0;
      exp_q.push_back(y_msg);
      tick();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus_a.o_tx_req !== 1'b0 || bus_a.o_tx_message !== 128'h0 || bus_a.o_txbsy !== 1'b0 || bus_a.dbg_state !== S_IDLE) begin
         n_err++; $display("FAIL rmid_async: got req %b msg %h bsy %b state %0d want 0 0 0 0",
            bus_a.o_tx_req, bus_a.o_tx_message, bus_a.o_txbsy, bus_a.dbg_state); end
      tick();
      rst_n = 1'b1;
      tick();
      n_cmp++; if (bus_a.o_tx_fifo_r_en !== 1'b1) begin n_err++; $display("FAIL rmid_refetch: got %b want 1", bus_a.o_tx_fifo_r_en); end
      bus_a.i_tx_empty = 1'b1;
      tick();
      n_cmp++; if (bus_a.o_tx_req !== 1'b1 || bus_a.o_tx_message !== exp_q[0]) begin
         n_err++; $display("FAIL rmid_msg: got req %b msg %h want 1 %h", bus_a.o_tx_req, bus_a.o_tx_message, exp_q[0]); end
      void'(exp_q.pop_front());
      pulse_done_a();
      n_cmp++; if (bus_a.o_txok !== 1'b1) begin n_err++; $display("FAIL rmid_ok: got %b want 1", bus_a.o_txok); end
      tick();
   endtask

   initial begin
      test_reset();
      test_fifo_basic();
      test_hpb_priority();
      test_retry_drop();
      test_retry_forever();
      test_coincident();
      test_stray_pulse();
      test_reset_mid();
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL queue_drain: got %0d left want 0", exp_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "bench timed out");
   end
endmodule
